// File: rtl/usb_tx_serializer.sv
// USB transmit serialiser: one-byte holding register, LSB-first shifting,
// bit stuffing, NRZI line coding and EOP generation, all paced by bit_strobe.
module usb_tx_serializer #(
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_strobe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_busy,
  output logic       stuff_hold,
  output logic       tx_done,
  output logic       tx_error
);
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int EW = $clog2(EOP_SE0_BITS + 1);
  localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
  localparam logic [EW-1:0] EOP_LAST  = EW'(EOP_SE0_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_STUFF   = 3'd2,
    ST_EOP_SE0 = 3'd3,
    ST_EOP_J   = 3'd4
  } state_t;

  state_t          state_r, state_nxt_s, bnd_state_s;
  logic [7:0]      hold_data_r, shift_r;
  logic            hold_last_r, last_r, tx_ready_r, hold_full_s;
  logic [2:0]      bit_idx_r, idx_nxt_s;
  logic [OW-1:0]   ones_r, ones_nxt_s, ones_inc_s;
  logic [EW-1:0]   eop_r, eop_nxt_s;
  logic            lvl_r, lvl_nxt_s, se0_nxt_s;
  logic            pend_r, pend_nxt_s, sh_nxt_s;
  logic            dplus_r, dminus_r, busy_r, stuff_hold_r, done_r, err_r;
  logic            consume_s, done_s, err_s, bnd_load_s, bnd_err_s, data_bit_s;

  assign hold_full_s = ~tx_ready_r;
  assign data_bit_s  = shift_r[bit_idx_r];
  assign ones_inc_s  = ones_r + OW'(1);

  // Byte-boundary outcome: finish the packet, reload from hold, or underrun
  always_comb begin
    if (last_r) begin
      bnd_state_s = ST_EOP_SE0;
      bnd_load_s  = 1'b0;
      bnd_err_s   = 1'b0;
    end else if (hold_full_s) begin
      bnd_state_s = ST_SHIFT;
      bnd_load_s  = 1'b1;
      bnd_err_s   = 1'b0;
    end else begin
      bnd_state_s = ST_EOP_SE0;
      bnd_load_s  = 1'b0;
      bnd_err_s   = 1'b1;
    end
  end

  // Next-state, counters and line level; everything advances only on a strobe
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = bit_idx_r;
    ones_nxt_s  = ones_r;
    eop_nxt_s   = eop_r;
    lvl_nxt_s   = lvl_r;
    se0_nxt_s   = ~(dplus_r | dminus_r);
    pend_nxt_s  = pend_r;
    sh_nxt_s    = stuff_hold_r;
    consume_s   = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;
    if (bit_strobe) begin
      case (state_r)
        ST_IDLE: begin
          se0_nxt_s = 1'b0;
          if (hold_full_s) begin
            consume_s   = 1'b1;
            lvl_nxt_s   = hold_data_r[0] ? lvl_r : ~lvl_r;
            ones_nxt_s  = hold_data_r[0] ? OW'(1) : '0;
            idx_nxt_s   = 3'd1;
            state_nxt_s = ST_SHIFT;
          end else begin
            lvl_nxt_s = 1'b1;
          end
        end
        ST_SHIFT: begin
          lvl_nxt_s  = data_bit_s ? lvl_r : ~lvl_r;
          ones_nxt_s = data_bit_s ? ones_inc_s : '0;
          idx_nxt_s  = bit_idx_r + 3'd1;
          if (data_bit_s && (ones_inc_s == STUFF_MAX)) begin
            // boundary decision is deferred until the stuff bit has gone out
            state_nxt_s = ST_STUFF;
            sh_nxt_s    = 1'b1;
            pend_nxt_s  = (bit_idx_r == 3'd7);
          end else if (bit_idx_r == 3'd7) begin
            state_nxt_s = bnd_state_s;
            consume_s   = bnd_load_s;
            err_s       = bnd_err_s;
            eop_nxt_s   = '0;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end
        ST_STUFF: begin
          lvl_nxt_s  = ~lvl_r;
          ones_nxt_s = '0;
          sh_nxt_s   = 1'b0;
          pend_nxt_s = 1'b0;
          if (pend_r) begin
            state_nxt_s = bnd_state_s;
            consume_s   = bnd_load_s;
            err_s       = bnd_err_s;
            eop_nxt_s   = '0;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end
        ST_EOP_SE0: begin
          se0_nxt_s = 1'b1;
          if (eop_r == EOP_LAST) begin
            state_nxt_s = ST_EOP_J;
            eop_nxt_s   = '0;
          end else begin
            eop_nxt_s = eop_r + EW'(1);
          end
        end
        ST_EOP_J: begin
          se0_nxt_s   = 1'b0;
          lvl_nxt_s   = 1'b1;
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end
        default: begin
          se0_nxt_s   = 1'b0;
          lvl_nxt_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Holding register: filled by the handshake, emptied when the shifter takes it
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_ready_r  <= 1'b1;
      hold_data_r <= 8'h00;
      hold_last_r <= 1'b0;
    end else if (consume_s) begin
      tx_ready_r <= 1'b1;
    end else if (tx_valid && tx_ready_r) begin
      hold_data_r <= tx_data;
      hold_last_r <= tx_last;
      tx_ready_r  <= 1'b0;
    end
  end

  // FSM state, shifter, counters and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r      <= ST_IDLE;
      shift_r      <= 8'h00;
      last_r       <= 1'b0;
      bit_idx_r    <= 3'd0;
      ones_r       <= '0;
      eop_r        <= '0;
      lvl_r        <= 1'b1;
      pend_r       <= 1'b0;
      dplus_r      <= 1'b1;
      dminus_r     <= 1'b0;
      busy_r       <= 1'b0;
      stuff_hold_r <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      bit_idx_r    <= idx_nxt_s;
      ones_r       <= ones_nxt_s;
      eop_r        <= eop_nxt_s;
      lvl_r        <= lvl_nxt_s;
      pend_r       <= pend_nxt_s;
      dplus_r      <= lvl_nxt_s & ~se0_nxt_s;
      dminus_r     <= ~lvl_nxt_s & ~se0_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
      stuff_hold_r <= sh_nxt_s;
      done_r       <= done_s;
      err_r        <= err_s;
      if (consume_s) begin
        shift_r <= hold_data_r;
        last_r  <= hold_last_r;
      end else begin
        shift_r <= shift_r;
      end
    end
  end

  assign tx_ready   = tx_ready_r;
  assign dplus_out  = dplus_r;
  assign dminus_out = dminus_r;
  assign tx_busy    = busy_r;
  assign stuff_hold = stuff_hold_r;
  assign tx_done    = done_r;
  assign tx_error   = err_r;
endmodule
